decode_execute_unit: RTL and testbench

- Single-stage decode/execute block for the unprivileged RV32E-style core. It combines the decoder, ALU and branch unit.
- It decodes a 32-bit instruction and drives register-file read addresses combinationally.
- It computes the ALU result and branch decision, and registers the writeback and branch outputs on the clock edge.
- It sits between instruction fetch / regfile read and regfile writeback / PC update.

---
 rtl/decode_execute_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_decode_execute_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// Single-stage decode/execute for an RV32E-style core: decoder, ALU and branch unit.
// Register-file read addresses are combinational; writeback and redirect outputs are registered.
// Optional feature macro: ALU_MINMAX_EN enables MIN/MINU/MAX/MAXU (OP, funct7=0000101).
module decode_execute_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_result,
  output logic              ex_reg_write,
  output logic              ex_take_branch,
  output logic [XLEN-1:0]   ex_branch_target,
  output logic              ex_illegal
);

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra,
    AluOr, AluAnd, AluMin, AluMinu, AluMax, AluMaxu
  } alu_op_e;

  typedef enum logic [1:0] {ResAlu, ResImm, ResPc4, ResPcImm} res_sel_e;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign rs1_addr = rs1[REG_AW-1:0];
  assign rs2_addr = rs2[REG_AW-1:0];

  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  alu_op_e         alu_op;
  res_sel_e        res_sel;
  logic [XLEN-1:0] imm;
  logic            use_imm, writes_rd, is_branch, is_jal, is_jalr, illegal;
  logic            uses_rd, uses_rs1, uses_rs2;

  // Instruction decode: classify opcode, pick immediate and ALU operation, flag illegal encodings
  always_comb begin
    alu_op    = AluAdd;
    res_sel   = ResAlu;
    imm       = imm_i;
    use_imm   = 1'b0;
    writes_rd = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    illegal   = 1'b0;
    uses_rd   = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    unique case (opcode)
      7'b0110011: begin // OP
        uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'b000: alu_op = AluAdd;
              3'b001: alu_op = AluSll;
              3'b010: alu_op = AluSlt;
              3'b011: alu_op = AluSltu;
              3'b100: alu_op = AluXor;
              3'b101: alu_op = AluSrl;
              3'b110: alu_op = AluOr;
              3'b111: alu_op = AluAnd;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      alu_op = AluSub;
            else if (funct3 == 3'b101) alu_op = AluSra;
            else                       illegal = 1'b1;
          end
`ifdef ALU_MINMAX_EN
          7'b0000101: begin
            if (!funct3[2]) illegal = 1'b1;
            else begin
              unique case (funct3[1:0])
                2'b00: alu_op = AluMin;
                2'b01: alu_op = AluMinu;
                2'b10: alu_op = AluMax;
                2'b11: alu_op = AluMaxu;
              endcase
            end
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      7'b0010011: begin // OP-IMM
        uses_rd = 1'b1; uses_rs1 = 1'b1; writes_rd = 1'b1; use_imm = 1'b1;
        unique case (funct3)
          3'b000: alu_op = AluAdd;
          3'b010: alu_op = AluSlt;
          3'b011: alu_op = AluSltu;
          3'b100: alu_op = AluXor;
          3'b110: alu_op = AluOr;
          3'b111: alu_op = AluAnd;
          3'b001: begin
            alu_op = AluSll;
            if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      alu_op = AluSrl;
            else if (funct7 == 7'b0100000) alu_op = AluSra;
            else                           illegal = 1'b1;
          end
        endcase
      end
      7'b0110111: begin // LUI
        uses_rd = 1'b1; writes_rd = 1'b1; res_sel = ResImm; imm = imm_u;
      end
      7'b0010111: begin // AUIPC
        uses_rd = 1'b1; writes_rd = 1'b1; res_sel = ResPcImm; imm = imm_u;
      end
      7'b1101111: begin // JAL
        uses_rd = 1'b1; writes_rd = 1'b1; res_sel = ResPc4; imm = imm_j; is_jal = 1'b1;
      end
      7'b1100111: begin // JALR
        uses_rd = 1'b1; uses_rs1 = 1'b1; writes_rd = 1'b1; res_sel = ResPc4; is_jalr = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      7'b1100011: begin // BRANCH
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_branch = 1'b1; imm = imm_b;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // RV32E has only x0..x15
    if ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4])) illegal = 1'b1;
  end

  logic [XLEN-1:0] op_b, alu_res, result, target;
  logic            lt_s, lt_u, br_cond;

  assign op_b = use_imm ? imm : rs2_val;
  assign lt_s = $signed(rs1_val) < $signed(op_b);
  assign lt_u = rs1_val < op_b;

  // ALU
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      AluAdd:  alu_res = rs1_val + op_b;
      AluSub:  alu_res = rs1_val - op_b;
      AluSll:  alu_res = rs1_val << op_b[4:0];
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      AluSltu: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      AluXor:  alu_res = rs1_val ^ op_b;
      AluSrl:  alu_res = rs1_val >> op_b[4:0];
      AluSra:  alu_res = $signed(rs1_val) >>> op_b[4:0];
      AluOr:   alu_res = rs1_val | op_b;
      AluAnd:  alu_res = rs1_val & op_b;
      AluMin:  alu_res = lt_s ? rs1_val : op_b;
      AluMinu: alu_res = lt_u ? rs1_val : op_b;
      AluMax:  alu_res = lt_s ? op_b : rs1_val;
      AluMaxu: alu_res = lt_u ? op_b : rs1_val;
      default: alu_res = '0;
    endcase
  end

  // Branch condition, writeback value selection and redirect target
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = lt_s;
      3'b101:  br_cond = !lt_s;
      3'b110:  br_cond = lt_u;
      3'b111:  br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
    unique case (res_sel)
      ResAlu:   result = alu_res;
      ResImm:   result = imm;
      ResPc4:   result = pc + 32'd4;
      ResPcImm: result = pc + imm;
    endcase
    target = is_jalr ? ((rs1_val + imm) & ~32'd1) : (pc + imm);
  end

  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d, target_q, target_d;
  logic              write_q, write_d, take_q, take_d, illegal_q, illegal_d;

  // Next-state for the registered ex_* outputs; control bits clear when no instruction
  always_comb begin
    rd_d      = rd_q;
    result_d  = result_q;
    target_d  = target_q;
    write_d   = 1'b0;
    take_d    = 1'b0;
    illegal_d = 1'b0;
    if (instr_valid) begin
      rd_d      = rd[REG_AW-1:0];
      target_d  = target;
      illegal_d = illegal;
      if (illegal) begin
        result_d = '0;
      end else begin
        result_d = result;
        write_d  = writes_rd && (rd != 5'd0);
        take_d   = is_jal || is_jalr || (is_branch && br_cond);
      end
    end
  end

  // Output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      result_q  <= '0;
      target_q  <= '0;
      write_q   <= 1'b0;
      take_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      result_q  <= result_d;
      target_q  <= target_d;
      write_q   <= write_d;
      take_q    <= take_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_rd            = rd_q;
  assign ex_result        = result_q;
  assign ex_reg_write     = write_q;
  assign ex_take_branch   = take_q;
  assign ex_branch_target = target_q;
  assign ex_illegal       = illegal_q;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed bench for decode_execute_unit with hand-computed expected values.
module tb_decode_execute_unit;

  logic        clk, rst_n, instr_valid;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic [3:0]  rs1_addr, rs2_addr, ex_rd;
  logic [31:0] ex_result, ex_branch_target;
  logic        ex_reg_write, ex_take_branch, ex_illegal;

  int total = 0;
  int bad   = 0;

  decode_execute_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .pc               (pc),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .ex_rd            (ex_rd),
    .ex_result        (ex_result),
    .ex_reg_write     (ex_reg_write),
    .ex_take_branch   (ex_take_branch),
    .ex_branch_target (ex_branch_target),
    .ex_illegal       (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one valid instruction, then sample just after the capturing edge
  task automatic run(input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b);
    instr = i; pc = p; rs1_val = a; rs2_val = b; instr_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
    #3;
    check_eq("rst_rd",      {28'b0, ex_rd}, 32'd0);
    check_eq("rst_result",  ex_result, 32'd0);
    check_eq("rst_write",   {31'b0, ex_reg_write}, 32'd0);
    check_eq("rst_take",    {31'b0, ex_take_branch}, 32'd0);
    check_eq("rst_target",  ex_branch_target, 32'd0);
    check_eq("rst_illegal", {31'b0, ex_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    instr = 32'h00500093; #1;
    check_eq("addi_rs1_addr", {28'b0, rs1_addr}, 32'd0);
    run(32'h00500093, 32'h0, 32'h0, 32'h0);
    check_eq("addi_result", ex_result, 32'd5);
    check_eq("addi_rd",     {28'b0, ex_rd}, 32'd1);
    check_eq("addi_write",  {31'b0, ex_reg_write}, 32'd1);
    check_eq("addi_illegal", {31'b0, ex_illegal}, 32'd0);

    // instr_valid=0: control clears, data holds
    instr_valid = 1'b0; instr = 32'h402081B3;
    @(posedge clk); #1;
    check_eq("nv_write",  {31'b0, ex_reg_write}, 32'd0);
    check_eq("nv_result", ex_result, 32'd5);
    check_eq("nv_rd",     {28'b0, ex_rd}, 32'd1);

    // SUB x3,x1,x2
    instr = 32'h402081B3; #1;
    check_eq("sub_rs1_addr", {28'b0, rs1_addr}, 32'd1);
    check_eq("sub_rs2_addr", {28'b0, rs2_addr}, 32'd2);
    run(32'h402081B3, 32'h0, 32'd5, 32'd7);
    check_eq("sub_result", ex_result, 32'hFFFFFFFE);
    check_eq("sub_rd",     {28'b0, ex_rd}, 32'd3);
    check_eq("sub_write",  {31'b0, ex_reg_write}, 32'd1);

    // BEQ x1,x2,+8 at pc 0x10
    run(32'h00208463, 32'h10, 32'd3, 32'd3);
    check_eq("beq_take",   {31'b0, ex_take_branch}, 32'd1);
    check_eq("beq_target", ex_branch_target, 32'h18);
    check_eq("beq_write",  {31'b0, ex_reg_write}, 32'd0);
    run(32'h00208463, 32'h10, 32'd3, 32'd4);
    check_eq("beq_nt_take", {31'b0, ex_take_branch}, 32'd0);

    // Signed vs unsigned branch compare
    run(32'h0020C463, 32'h10, 32'hFFFFFFFF, 32'd1);
    check_eq("blt_take", {31'b0, ex_take_branch}, 32'd1);
    run(32'h0020E463, 32'h10, 32'hFFFFFFFF, 32'd1);
    check_eq("bltu_take", {31'b0, ex_take_branch}, 32'd0);

    // SLT / SLTU
    run(32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'd1);
    check_eq("slt_result", ex_result, 32'd1);
    run(32'h0020B1B3, 32'h0, 32'hFFFFFFFF, 32'd1);
    check_eq("sltu_result", ex_result, 32'd0);

    // SRAI x1,x1,4
    run(32'h4040D093, 32'h0, 32'h80000000, 32'h0);
    check_eq("srai_result", ex_result, 32'hF8000000);

    // LUI x1,0x12345
    run(32'h123450B7, 32'h0, 32'h0, 32'h0);
    check_eq("lui_result", ex_result, 32'h12345000);

    // AUIPC x1,0x1 at pc 0x200
    run(32'h00001097, 32'h200, 32'h0, 32'h0);
    check_eq("auipc_result", ex_result, 32'h1200);

    // JALR x1,4(x2) at pc 0x300 with rs1=0x1001
    run(32'h004100E7, 32'h300, 32'h1001, 32'h0);
    check_eq("jalr_result", ex_result, 32'h304);
    check_eq("jalr_target", ex_branch_target, 32'h1004);
    check_eq("jalr_take",   {31'b0, ex_take_branch}, 32'd1);

    // ADD x0,x1,x2: no write to x0
    run(32'h00208033, 32'h0, 32'd1, 32'd2);
    check_eq("x0_write", {31'b0, ex_reg_write}, 32'd0);

    // ADDI x16,x0,5: illegal register
    run(32'h00500813, 32'h0, 32'h0, 32'h0);
    check_eq("x16_illegal", {31'b0, ex_illegal}, 32'd1);
    check_eq("x16_write",   {31'b0, ex_reg_write}, 32'd0);
    check_eq("x16_result",  ex_result, 32'd0);

    // LW: unsupported opcode
    run(32'h00002083, 32'h0, 32'h0, 32'h0);
    check_eq("load_illegal", {31'b0, ex_illegal}, 32'd1);

    // MIN x3,x1,x2
    run(32'h0A20C1B3, 32'h0, 32'hFFFFFFFF, 32'd1);
`ifdef ALU_MINMAX_EN
    check_eq("min_result",  ex_result, 32'hFFFFFFFF);
    check_eq("min_illegal", {31'b0, ex_illegal}, 32'd0);
`else
    check_eq("min_illegal", {31'b0, ex_illegal}, 32'd1);
    check_eq("min_write",   {31'b0, ex_reg_write}, 32'd0);
`endif

    // JAL x1,+8 at pc 0x100, then asynchronous reset mid-cycle
    run(32'h008000EF, 32'h100, 32'h0, 32'h0);
    check_eq("jal_result", ex_result, 32'h104);
    check_eq("jal_target", ex_branch_target, 32'h108);
    check_eq("jal_take",   {31'b0, ex_take_branch}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_result", ex_result, 32'd0);
    check_eq("arst_target", ex_branch_target, 32'd0);
    check_eq("arst_rd",     {28'b0, ex_rd}, 32'd0);
    check_eq("arst_write",  {31'b0, ex_reg_write}, 32'd0);
    check_eq("arst_take",   {31'b0, ex_take_branch}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
